// File: rtl/clk_div_pkg.sv
// Shared types and the code-to-half-period lookup for the multi-channel clock divider.
package clk_div_pkg;

   localparam int DEF_SEL_W = 4;

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } chan_state_e;

   // HALF(k) = max(1, base >> (k-1)) with base first truncated to cnt_w bits; code 0 means stopped
   function automatic logic [31:0] half_period(input logic [15:0] code,
                                               input logic [31:0] base,
                                               input int          cnt_w);
      logic [31:0] w_mask;
      logic [31:0] w_shift;
      if (cnt_w >= 32) begin
         w_mask = 32'hFFFF_FFFF;
      end else begin
         w_mask = (32'd1 << cnt_w) - 32'd1;
      end
      if (code == 16'd0) begin
         half_period = 32'd0;
      end else begin
         w_shift = (base & w_mask) >> (code - 16'd1);
         if (w_shift == 32'd0) begin
            half_period = 32'd1;
         end else begin
            half_period = w_shift;
         end
      end
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: optional switch synchroniser (CLK_DIV_SYNC_EN), pending/active
// half-period registers, half-period counter, 50% output and rising-edge tick.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int SEL_W     = DEF_SEL_W,
   parameter int CNT_W     = 27,
   parameter int BASE_HALF = 50_000_000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_en,
   output logic             o_clk,
   output logic             o_tick
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SEL_W-1:0] w_code;
   logic [CNT_W-1:0] w_half;
   logic             w_last;

   chan_state_e      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_act_half;
   logic [CNT_W-1:0] r_pend_half;
   logic             r_clk;
   logic             r_tick;

`ifdef CLK_DIV_SYNC_EN
   logic [SEL_W-1:0] r_sync1;
   logic [SEL_W-1:0] r_sync2;

   // Two-flop synchroniser on every switch bit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= {SEL_W{1'b0}};
         r_sync2 <= {SEL_W{1'b0}};
      end else begin
         r_sync1 <= i_sel;
         r_sync2 <= r_sync1;
      end
   end

   assign w_code = r_sync2;
`else
   assign w_code = i_sel;
`endif

   assign w_half = CNT_W'(half_period(16'(w_code), 32'(BASE_HALF), CNT_W));
   assign w_last = (r_cnt == (r_act_half - ONE));

   // Pending half-period follows the (synchronised) code every cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend_half <= {CNT_W{1'b0}};
      end else begin
         r_pend_half <= w_half;
      end
   end

   // Channel FSM: rate is only reloaded at half-period boundaries, so no runt phases
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= STOPPED;
         r_cnt      <= {CNT_W{1'b0}};
         r_act_half <= {CNT_W{1'b0}};
         r_clk      <= 1'b0;
         r_tick     <= 1'b0;
      end else if (!i_en) begin
         r_state    <= STOPPED;
         r_cnt      <= {CNT_W{1'b0}};
         r_act_half <= {CNT_W{1'b0}};
         r_clk      <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         case (r_state)
            STOPPED: begin
               r_tick <= 1'b0;
               r_clk  <= 1'b0;
               r_cnt  <= {CNT_W{1'b0}};
               if (r_pend_half != {CNT_W{1'b0}}) begin
                  r_act_half <= r_pend_half;
                  r_state    <= RUNNING;
               end else begin
                  r_act_half <= {CNT_W{1'b0}};
                  r_state    <= STOPPED;
               end
            end
            RUNNING: begin
               if (w_last) begin
                  r_cnt <= {CNT_W{1'b0}};
                  if (r_pend_half == {CNT_W{1'b0}}) begin
                     if (r_clk) begin
                        r_clk      <= 1'b0;
                        r_tick     <= 1'b0;
                        r_act_half <= {CNT_W{1'b0}};
                        r_state    <= STOPPED;
                     end else begin
                        // keep the old rate so the final high phase is full length
                        r_clk  <= 1'b1;
                        r_tick <= 1'b1;
                     end
                  end else begin
                     r_clk      <= ~r_clk;
                     r_tick     <= ~r_clk;
                     r_act_half <= r_pend_half;
                  end
               end else begin
                  r_cnt  <= r_cnt + ONE;
                  r_tick <= 1'b0;
               end
            end
            default: begin
               r_state    <= STOPPED;
               r_cnt      <= {CNT_W{1'b0}};
               r_act_half <= {CNT_W{1'b0}};
               r_clk      <= 1'b0;
               r_tick     <= 1'b0;
            end
         endcase
      end
   end

   assign o_clk  = r_clk;
   assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// N_CH-channel switch-selectable clock divider; CLK_DIV_SYNC_EN adds a 2-flop
// synchroniser on the rate switches of every channel.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int N_CH      = 2,
   parameter int SEL_W     = DEF_SEL_W,
   parameter int CNT_W     = 27,
   parameter int BASE_HALF = 50_000_000
) (
   input  logic                  DIV_MASTER_CLK,
   input  logic                  DIV_RST_N,
   input  logic [N_CH*SEL_W-1:0] CLK_DIV_SW,
   input  logic [N_CH-1:0]       CH_EN,
   output logic [N_CH-1:0]       STAB_CLK,
   output logic [N_CH-1:0]       TICK_OUT
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      clk_div_chan #(
         .SEL_W     (SEL_W),
         .CNT_W     (CNT_W),
         .BASE_HALF (BASE_HALF)
      ) u_chan (
         .i_clk   (DIV_MASTER_CLK),
         .i_rst_n (DIV_RST_N),
         .i_sel   (CLK_DIV_SW[g*SEL_W +: SEL_W]),
         .i_en    (CH_EN[g]),
         .o_clk   (STAB_CLK[g]),
         .o_tick  (TICK_OUT[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi with BASE_HALF=8: per-cycle expected waveforms are queued
// when stimulus is applied and compared on every falling edge.
module tb_clk_div_multi;

`ifdef CLK_DIV_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] sw;
   logic [1:0] en;
   logic [1:0] stab;
   logic [1:0] tick;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [1:0] chk;
      logic [1:0] s;
      logic [1:0] t;
      int         seg;
      int         n;
   } exp_t;

   typedef struct {
      logic [3:0] code;
      int         half;
      int         ncyc;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[7];

   clk_div_multi #(
      .N_CH      (2),
      .SEL_W     (4),
      .CNT_W     (5),
      .BASE_HALF (8)
   ) dut (
      .DIV_MASTER_CLK (clk),
      .DIV_RST_N      (rst_n),
      .CLK_DIV_SW     (sw),
      .CH_EN          (en),
      .STAB_CLK       (stab),
      .TICK_OUT       (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic fs(input int n, input int n0, input int h);
      if (h == 0 || n < n0) return 1'b0;
      return ((n - n0) % (2 * h)) < h;
   endfunction

   function automatic logic ft(input int n, input int n0, input int h);
      if (h == 0 || n < n0) return 1'b0;
      return ((n - n0) % (2 * h)) == 0;
   endfunction

   // Scoreboard: one queued expectation per falling edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         for (int c = 0; c < 2; c++) begin
            if (e.chk[c]) begin
               n_cmp++;
               if (stab[c] !== e.s[c]) begin
                  n_fail++;
                  $display("FAIL stab ch%0d seg%0d n%0d: got %b want %b", c, e.seg, e.n, stab[c], e.s[c]);
               end
               n_cmp++;
               if (tick[c] !== e.t[c]) begin
                  n_fail++;
                  $display("FAIL tick ch%0d seg%0d n%0d: got %b want %b", c, e.seg, e.n, tick[c], e.t[c]);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] chk, input logic [1:0] s, input logic [1:0] t,
                       input int seg, input int n);
      exp_t e;
      e.chk = chk;
      e.s   = s;
      e.t   = t;
      e.seg = seg;
      e.n   = n;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0) begin
         step();
         g++;
         if (g > 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
         end
      end
   endtask

   task automatic check_zero(input int tag);
      n_cmp++;
      if (stab !== 2'b00 || tick !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_outputs tag%0d: got stab %b tick %b want 00 00", tag, stab, tick);
      end
   endtask

   task automatic prep(input logic [3:0] c0, input logic [3:0] c1);
      en = 2'b00;
      sw = {c1, c0};
      repeat (L + 3) step();
   endtask

   initial begin
      logic s0, t0, s1, t1;
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      en     = 2'b00;
      sw     = 8'h00;

      vecs[0] = '{code: 4'd1,  half: 8, ncyc: 40};
      vecs[1] = '{code: 4'd2,  half: 4, ncyc: 40};
      vecs[2] = '{code: 4'd3,  half: 2, ncyc: 40};
      vecs[3] = '{code: 4'd4,  half: 1, ncyc: 40};
      vecs[4] = '{code: 4'd5,  half: 1, ncyc: 40};
      vecs[5] = '{code: 4'd15, half: 1, ncyc: 40};
      vecs[6] = '{code: 4'd0,  half: 0, ncyc: 40};

      repeat (2) step();
      check_zero(0);
      rst_n = 1'b1;
      step();

      // Table: ch0 restarted by enable with a settled code; first rise HALF cycles after entry
      for (int i = 0; i < 7; i++) begin
         prep(vecs[i].code, 4'd0);
         en = 2'b01;
         for (int n = 1; n <= vecs[i].ncyc; n++) begin
            push(2'b11, {1'b0, fs(n, 1 + vecs[i].half, vecs[i].half)},
                 {1'b0, ft(n, 1 + vecs[i].half, vecs[i].half)}, i, n);
         end
         drain();
      end

      // Code 1 -> 2 in the middle of the first high phase
      prep(4'd1, 4'd0);
      en = 2'b01;
      for (int n = 1; n <= 48; n++) begin
         if (n <= 16) begin
            s0 = fs(n, 9, 8);
            t0 = ft(n, 9, 8);
         end else begin
            s0 = ((n - 17) % 8) >= 4;
            t0 = (n >= 21) && (((n - 21) % 8) == 0);
         end
         push(2'b11, {1'b0, s0}, {1'b0, t0}, 10, n);
      end
      repeat (12) step();
      sw[3:0] = 4'd2;
      drain();

      // Code -> 0 during a low phase: one more full high phase, then stop
      prep(4'd1, 4'd0);
      en = 2'b01;
      for (int n = 1; n <= 60; n++) begin
         s0 = (n <= 32) ? fs(n, 9, 8) : 1'b0;
         t0 = (n <= 32) ? ft(n, 9, 8) : 1'b0;
         push(2'b11, {1'b0, s0}, {1'b0, t0}, 11, n);
      end
      repeat (18) step();
      sw[3:0] = 4'd0;
      drain();

      // CH_EN[1] dropped mid-high; ch0 keeps running
      prep(4'd1, 4'd1);
      en = 2'b11;
      for (int n = 1; n <= 40; n++) begin
         s0 = fs(n, 9, 8);
         t0 = ft(n, 9, 8);
         s1 = (n <= 11) ? fs(n, 9, 8) : 1'b0;
         t1 = (n <= 11) ? ft(n, 9, 8) : 1'b0;
         push(2'b11, {s1, s0}, {t1, t0}, 12, n);
      end
      repeat (11) step();
      en[1] = 1'b0;
      drain();

      // One-cycle reset mid-period, then a fresh start through the switch path
      prep(4'd1, 4'd3);
      en = 2'b11;
      for (int n = 1; n <= 13; n++) begin
         push(2'b11, {fs(n, 3, 2), fs(n, 9, 8)}, {ft(n, 3, 2), ft(n, 9, 8)}, 13, n);
      end
      drain();
      rst_n = 1'b0;
      #1;
      check_zero(1);
      step();
      check_zero(2);
      rst_n = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         push(2'b11, {fs(n, L + 4, 2), fs(n, L + 10, 8)},
              {ft(n, L + 4, 2), ft(n, L + 10, 8)}, 14, n);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel switch-selectable clock divider. It generates N_CH independent 50%-duty divided clocks and matching one-cycle rising-edge tick strobes, all from the board master clock. Each channel's rate is chosen at runtime by a 4-bit switch code. Rate changes take effect glitch-free, only at half-period boundaries. It replaces the single-channel switch/divider pair and feeds the display-scan, debounce and game-tick logic.

## Interface
Parameters:
- N_CH, 2: number of independent channels.
- SEL_W, 4: width of each channel's rate-select code.
- CNT_W, 27: half-period counter width. Must satisfy 2^CNT_W > BASE_HALF.
- BASE_HALF, 50_000_000: half-period in master cycles for code 1 (1 Hz at 100 MHz).

Ports (the clock is single; reset is asynchronous, active-low):
- DIV_MASTER_CLK, input, 1: master clock; all logic is on its rising edge.
- DIV_RST_N, input, 1: asynchronous active-low reset.
- CLK_DIV_SW, input, N_CH*SEL_W: rate codes. Channel c uses bits [c*SEL_W +: SEL_W]. Asynchronous (switches).
- CH_EN, input, N_CH: per-channel enable, synchronous to DIV_MASTER_CLK.
- STAB_CLK, output, N_CH: divided 50%-duty clocks (registered).
- TICK_OUT, output, N_CH: one-cycle strobe, asserted in the cycle the matching STAB_CLK bit rises.

## Operation
- Code to half-period mapping:
  - Code 0 means the channel is stopped.
  - Code k (1..2^SEL_W−1) gives HALF(k) = max(1, BASE_HALF >> (k−1)).
  - The shift is evaluated in CNT_W bits and is floor-truncated.
- Each channel holds these registers:
  - cnt[CNT_W]
  - active half-period act_half (0 means stopped)
  - pending half-period pend_half
  - STAB_CLK bit
- Per-channel states:
  - STOPPED: act_half=0, output low, cnt=0.
  - RUNNING: act_half≠0.
- Every cycle, pend_half ← HALF(synchronised code).
- STOPPED → RUNNING:
  - Triggered when pend_half≠0 and CH_EN=1.
  - On that edge: act_half←pend_half, cnt←0. Output stays low.
- RUNNING, cnt ≠ act_half−1: cnt increments.
- RUNNING, cnt == act_half−1 (boundary):
  - Output toggles and cnt←0.
  - act_half←pend_half. This is the only point where the rate changes, so no runt pulse occurs.
  - Exception: pend_half=0 while the output is high. The output falls, and the channel enters STOPPED on this same edge.
  - If pend_half=0 while the output is low, the channel keeps its current act_half until the next (falling) boundary.
- TICK_OUT is asserted on a boundary where the output goes 0→1, and only for that cycle.
- CH_EN=0:
  - Takes effect on the next edge, independent of boundaries.
  - cnt←0, output←0, act_half←0, no tick.
  - This is a deliberate, documented truncation.
- Simultaneous boundary plus code change: the code already in pend_half on that edge is used.

## Timing
- Reset: STAB_CLK=0, TICK_OUT=0, cnt=0, act_half=0, pend_half=0, synchroniser stages=0.
- Period for code k: 2·HALF(k) cycles. The first rising edge comes HALF(k) cycles after entering RUNNING.
- Switch-to-pending latency:
  - 3 cycles with the synchroniser compiled in (2 sync + pend).
  - 1 cycle without it.
- Reset asserted mid-period clears everything immediately, with no completion of the current period.

## Configuration
- CLK_DIV_SYNC_EN:
  - Defined: each CLK_DIV_SW bit passes through a 2-flop synchroniser before the HALF() lookup.
  - Undefined: CLK_DIV_SW feeds the lookup directly. Use this only when codes come from a synchronous source. Latency drops by 2 cycles; behaviour is otherwise identical.

## Structure
- Package clk_div_pkg holds:
  - default SEL_W
  - the channel state enum (STOPPED, RUNNING)
  - the function half_period(code, base, cnt_w) implementing HALF(k), including the clamp to 1
- Sub-module clk_div_chan implements one channel (synchroniser, pend/act registers, counter, output, tick).
- clk_div_multi is a generate loop over N_CH instances plus bus slicing.

## Test plan
All scenarios use BASE_HALF=8, N_CH=2, sync enabled.
- Reset, then ch0 code 1 with CH_EN=1:
  - STAB_CLK[0] has period 16, 8 high / 8 low.
  - First rise 8 cycles after RUNNING entry.
  - TICK_OUT[0] is one cycle wide, once per 16 cycles.
- Code 4, and code 5 (clamp):
  - Both give HALF=1, so output toggles every cycle.
  - TICK every 2 cycles.
- Change ch0 code 1→2 mid-high-phase:
  - Current 8-cycle high phase completes.
  - Subsequent half-periods are 4.
  - No phase shorter than 4 or longer than 8.
- Code →0 while output low:
  - Finishes low phase, completes a full 8-cycle high phase, falls, then stays low.
  - No tick after the fall.
- CH_EN[1] deassert mid-high: STAB_CLK[1]=0 next cycle, while ch0 is unaffected.
- DIV_RST_N low for 1 cycle at an arbitrary point:
  - All outputs 0.
  - Restart timing matches a fresh start (3-cycle sync latency + 8).
